// File: rtl/idli_pkg.sv
// Shared types for the idli core.
// Holds the SQI nibble type and the UART receive FSM states.
package idli_pkg;

  typedef logic [3:0] sqi_data_t;

  typedef enum logic [3:0] {
    UART_RX_IDLE,
    UART_RX_DATA_0,
    UART_RX_DATA_1,
    UART_RX_DATA_2,
    UART_RX_DATA_3,
    UART_RX_DATA_4,
    UART_RX_DATA_5,
    UART_RX_DATA_6,
    UART_RX_DATA_7,
    UART_RX_STOP,
    UART_RX_WAIT_HIGH
  } uart_rx_state_t;

endpackage

// File: rtl/idli_sync_m.sv
// N-flop synchroniser for an async input; flops reset to 1.
// Ports: clk, rst_n (async low), d (async in), q (synchronised out).
module idli_sync_m #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [N-1:0] sync_q;
  logic [N-1:0] sync_d;

  always_comb begin
    sync_d[0] = d;
    for (int i = 1; i < N; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[N-1];

endmodule

// File: rtl/idli_uart_rx_m.sv
// UART receiver: 1 bit per clock, 8N1, byte handed out as two nibbles.
// Ports: gck/rst_n, rx pin, nibble out with vld/acp, ovf and err pulses.
module idli_uart_rx_m
  import idli_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic      i_uart_gck,
  input  logic      i_uart_rst_n,
  input  logic      i_uart_rx,
  output sqi_data_t o_uart_rx,
  output logic      o_uart_rx_vld,
  input  logic      i_uart_rx_acp,
  output logic      o_uart_rx_ovf,
  output logic      o_uart_rx_err
);

  logic           rx_s;
  logic           xfer;
  logic           wr_ok;

  uart_rx_state_t state_q, state_d;
  logic [7:0]     shift_q, shift_d;
  logic [7:0]     buf_q, buf_d;
  logic           full_q, full_d;
  logic           ptr_q, ptr_d;
  logic           ovf_q, ovf_d;
  logic           err_q, err_d;

  idli_sync_m #(
    .N (SYNC_STAGES)
  ) u_sync (
    .clk   (i_uart_gck),
    .rst_n (i_uart_rst_n),
    .d     (i_uart_rx),
    .q     (rx_s)
  );

  assign xfer  = full_q & i_uart_rx_acp;
  // A new byte fits if empty or the last nibble leaves this cycle.
  assign wr_ok = ~full_q | (xfer & ptr_q);

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    buf_d   = buf_q;
    full_d  = full_q;
    ptr_d   = ptr_q;
    ovf_d   = 1'b0;
    err_d   = 1'b0;

    if (xfer) begin
      if (ptr_q) begin
        full_d = 1'b0;
        ptr_d  = 1'b0;
      end else begin
        ptr_d = 1'b1;
      end
    end

    unique case (state_q)
      UART_RX_IDLE: begin
        if (!rx_s) state_d = UART_RX_DATA_0;
      end
      UART_RX_DATA_0,
      UART_RX_DATA_1,
      UART_RX_DATA_2,
      UART_RX_DATA_3,
      UART_RX_DATA_4,
      UART_RX_DATA_5,
      UART_RX_DATA_6: begin
        shift_d = {rx_s, shift_q[7:1]};
        state_d = uart_rx_state_t'(state_q + 4'd1);
      end
      UART_RX_DATA_7: begin
        shift_d = {rx_s, shift_q[7:1]};
        state_d = UART_RX_STOP;
      end
      UART_RX_STOP: begin
        if (rx_s) begin
          state_d = UART_RX_IDLE;
          if (wr_ok) begin
            buf_d  = shift_q;
            full_d = 1'b1;
            ptr_d  = 1'b0;
          end else begin
            ovf_d = 1'b1;
          end
        end else begin
          err_d   = 1'b1;
          state_d = UART_RX_WAIT_HIGH;
        end
      end
      UART_RX_WAIT_HIGH: begin
        if (rx_s) state_d = UART_RX_IDLE;
      end
      default: begin
        state_d = UART_RX_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_uart_gck or negedge i_uart_rst_n) begin
    if (!i_uart_rst_n) begin
      state_q <= UART_RX_IDLE;
      buf_q   <= '0;
      full_q  <= 1'b0;
      ptr_q   <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      full_q  <= full_d;
      ptr_q   <= ptr_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  // Assembly register: contents only matter once a frame completes.
  always_ff @(posedge i_uart_gck) begin
    shift_q <= shift_d;
  end

  assign o_uart_rx     = ptr_q ? buf_q[7:4] : buf_q[3:0];
  assign o_uart_rx_vld = full_q;
  assign o_uart_rx_ovf = ovf_q;
  assign o_uart_rx_err = err_q;

endmodule

// File: tb/tb_idli_uart_rx_m.sv
// Testbench for idli_uart_rx_m.
// Table vectors, directed corner cases and a random frame stream.
module tb_idli_uart_rx_m;
  import idli_pkg::*;

  localparam int SYNC = 2;

  logic      clk   = 1'b0;
  logic      rst_n = 1'b0;
  logic      rx    = 1'b1;
  logic      acp   = 1'b0;
  sqi_data_t nib;
  logic      vld;
  logic      ovf;
  logic      err;

  always #5 clk = ~clk;

  idli_uart_rx_m #(
    .SYNC_STAGES (SYNC)
  ) dut (
    .i_uart_gck    (clk),
    .i_uart_rst_n  (rst_n),
    .i_uart_rx     (rx),
    .o_uart_rx     (nib),
    .o_uart_rx_vld (vld),
    .i_uart_rx_acp (acp),
    .o_uart_rx_ovf (ovf),
    .o_uart_rx_err (err)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [3:0] got_q[$];
  int         got_cyc[$];
  int         rise_q[$];
  int         ovf_cnt  = 0;
  int         err_cnt  = 0;
  logic       vld_prev = 1'b0;

  always @(negedge clk) begin
    if (vld && acp) begin
      got_q.push_back(nib);
      got_cyc.push_back(cyc);
    end
    if (ovf) ovf_cnt++;
    if (err) err_cnt++;
    if (vld && !vld_prev) rise_q.push_back(cyc);
    vld_prev = vld;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic chk_nibs(input string name, input int base,
                          input logic [3:0] e[$]);
    chk({name, " count"}, got_q.size() - base, e.size());
    foreach (e[i]) begin
      if (base + i < got_q.size())
        chk(name, int'(got_q[base+i]), int'(e[i]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    tick();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic idle(input int n);
    repeat (n) send_bit(1'b1);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic [3:0] lo;
    logic [3:0] hi;
    int         errs;
  } vec_t;

  vec_t       tbl[5];
  logic [3:0] e[$];
  logic [3:0] model_q[$];
  int         base, rb, c0, o0, r0, model_err;

  initial begin
    tbl[0] = '{8'h00, 1'b1, 4'h0, 4'h0, 0};
    tbl[1] = '{8'hFF, 1'b1, 4'hF, 4'hF, 0};
    tbl[2] = '{8'h96, 1'b1, 4'h6, 4'h9, 0};
    tbl[3] = '{8'h5A, 1'b0, 4'h0, 4'h0, 1};
    tbl[4] = '{8'h01, 1'b1, 4'h1, 4'h0, 0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst vld", vld, 0);
    chk("rst nib", nib, 0);
    chk("rst ovf", ovf, 0);
    chk("rst err", err, 0);
    rst_n = 1'b1;
    idle(4);
    chk("idle vld", vld, 0);

    // single byte with latency check
    acp  = 1'b1;
    base = got_q.size();
    rb   = rise_q.size();
    o0   = ovf_cnt;
    r0   = err_cnt;
    c0   = cyc;
    send_frame(8'hA5, 1'b1);
    idle(6);
    chk("latency", (rise_q.size() > rb) ? rise_q[rb] - c0 : -1,
        SYNC + 10);
    e = '{4'h5, 4'hA};
    chk_nibs("single", base, e);
    chk("single back2back nib",
        (got_q.size() >= base + 2) ? got_cyc[base+1] - got_cyc[base] : -1,
        1);
    chk("single ovf", ovf_cnt - o0, 0);
    chk("single err", err_cnt - r0, 0);

    // table vectors
    foreach (tbl[i]) begin
      base = got_q.size();
      r0   = err_cnt;
      send_frame(tbl[i].data, tbl[i].stop);
      if (!tbl[i].stop) begin
        send_bit(1'b0);
        send_bit(1'b0);
      end
      idle(6);
      if (tbl[i].stop) e = '{tbl[i].lo, tbl[i].hi};
      else e = {};
      chk_nibs($sformatf("tbl%0d", i), base, e);
      chk($sformatf("tbl%0d err", i), err_cnt - r0, tbl[i].errs);
    end

    // back-to-back frames, single high between
    base = got_q.size();
    o0   = ovf_cnt;
    send_frame(8'h3C, 1'b1);
    send_frame(8'hF0, 1'b1);
    idle(8);
    e = '{4'hC, 4'h3, 4'h0, 4'hF};
    chk_nibs("b2b", base, e);
    chk("b2b ovf", ovf_cnt - o0, 0);

    // backpressure and overflow
    acp  = 1'b0;
    base = got_q.size();
    o0   = ovf_cnt;
    send_frame(8'h12, 1'b1);
    idle(3);
    send_frame(8'h34, 1'b1);
    idle(6);
    chk("ovf pulses", ovf_cnt - o0, 1);
    chk("ovf hold vld", vld, 1);
    chk("ovf hold nib", nib, 2);
    acp = 1'b1;
    idle(4);
    e = '{4'h2, 4'h1};
    chk_nibs("ovf drain", base, e);
    chk("ovf vld drop", vld, 0);

    // last nibble leaves in the stop cycle of the next byte
    acp  = 1'b0;
    base = got_q.size();
    rb   = rise_q.size();
    o0   = ovf_cnt;
    send_frame(8'h12, 1'b1);
    idle(3);
    acp = 1'b1;
    tick();
    acp = 1'b0;
    idle(2);
    send_frame(8'h34, 1'b1);
    idle(SYNC - 1);
    acp = 1'b1;
    send_bit(1'b1);
    acp = 1'b0;
    chk("drain vld", vld, 1);
    chk("drain nib", nib, 4);
    acp = 1'b1;
    idle(4);
    e = '{4'h2, 4'h1, 4'h4, 4'h3};
    chk_nibs("drain", base, e);
    chk("drain ovf", ovf_cnt - o0, 0);
    chk("drain rises", rise_q.size() - rb, 1);

    // framing error with a long low run
    base = got_q.size();
    rb   = rise_q.size();
    r0   = err_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(i[0] ? 1'b0 : 1'b1);
    repeat (4) send_bit(1'b0);
    idle(6);
    chk("ferr pulses", err_cnt - r0, 1);
    chk("ferr rises", rise_q.size() - rb, 0);
    send_frame(8'h77, 1'b1);
    idle(6);
    e = '{4'h7, 4'h7};
    chk_nibs("ferr next", base, e);
    chk("ferr next err", err_cnt - r0, 1);

    // reset mid-frame with a byte buffered
    acp  = 1'b0;
    base = got_q.size();
    o0   = ovf_cnt;
    r0   = err_cnt;
    send_frame(8'h99, 1'b1);
    idle(3);
    chk("pre-rst vld", vld, 1);
    send_bit(1'b0);
    for (int i = 0; i < 4 + SYNC; i++) send_bit(i[0]);
    rx    = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mid-rst vld", vld, 0);
    tick();
    tick();
    rst_n = 1'b1;
    idle(4);
    chk("post-rst vld", vld, 0);
    acp = 1'b1;
    send_frame(8'h81, 1'b1);
    idle(6);
    e = '{4'h1, 4'h8};
    chk_nibs("post-rst", base, e);
    chk("rst ovf", ovf_cnt - o0, 0);
    chk("rst err", err_cnt - r0, 0);

    // random frame stream against a byte-level model
    base      = got_q.size();
    o0        = ovf_cnt;
    r0        = err_cnt;
    model_err = 0;
    model_q   = {};
    for (int k = 0; k < 30; k++) begin
      logic [7:0] d;
      d = 8'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        send_frame(d, 1'b0);
        repeat ($urandom_range(0, 3)) send_bit(1'b0);
        idle($urandom_range(1, 3));
        model_err++;
      end else begin
        send_frame(d, 1'b1);
        idle($urandom_range(0, 3));
        model_q.push_back(d[3:0]);
        model_q.push_back(d[7:4]);
      end
    end
    idle(8);
    chk_nibs("rand", base, model_q);
    chk("rand err", err_cnt - r0, model_err);
    chk("rand ovf", ovf_cnt - o0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/idli_uart_rx_m.md
Name: idli_uart_rx_m

Overview:
UART receiver, the counterpart of the core's UART transmitter on the same serial link.
- Line format: one bit per i_uart_gck cycle, no baud divider. Idle high, one start bit (0), eight data bits LSB first, then at least one high cycle.
- Received bytes are buffered and handed to the core as two 4b sqi_data_t nibbles, low nibble first, over a valid/accept handshake.

Parameters:
SYNC_STAGES, 2, number of flops synchronising i_uart_rx into the i_uart_gck domain (legal 1..4).

Ports:
i_uart_gck      input   1   clock
i_uart_rst_n    input   1   asynchronous active-low reset
i_uart_rx       input   1   serial line; idle high
o_uart_rx       output  4   sqi_data_t nibble to the core
o_uart_rx_vld   output  1   o_uart_rx holds a valid nibble
i_uart_rx_acp   input   1   core accepts the nibble; transfer when vld && acp
o_uart_rx_ovf   output  1   one-cycle pulse: completed byte dropped, buffer full
o_uart_rx_err   output  1   one-cycle pulse: framing error, byte dropped

Behaviour:
- Clock and reset: one clock, i_uart_gck. Reset i_uart_rst_n is asynchronous, active-low.
- Reset values:
  - all synchroniser flops 1
  - state IDLE
  - buffer empty, o_uart_rx_vld 0
  - o_uart_rx_ovf 0, o_uart_rx_err 0
  - o_uart_rx: don't-care when vld is 0; drive 0 out of reset
- The FSM sees only the synchronised line rx_s. rx_s lags the pin by SYNC_STAGES cycles.
- FSM states: IDLE, DATA_0..DATA_7, STOP, WAIT_HIGH.
  - IDLE: rx_s==0 -> DATA_0 (start bit consumed); else stay.
  - DATA_n: shift rx_s into bit n of the assembly register (LSB first); advance to DATA_n+1. DATA_7 -> STOP.
  - STOP, rx_s==1: byte complete -> IDLE. The same cycle attempts a buffer write (see below).
  - STOP, rx_s==0: pulse o_uart_rx_err, discard byte -> WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s==1, then -> IDLE. A low line never starts a frame from this state.
- Frame timing: start sampled in cycle S, data in S+1..S+8, stop in S+9. Byte enters the buffer at the end of S+9. o_uart_rx_vld rises in S+10.
- Back-to-back frames: the transmitter guarantees at least one high cycle between frames. A start bit at S+10 is legal and must be received.
- Output buffer: one byte plus a nibble pointer (LO/HI).
  - When full: o_uart_rx_vld=1; o_uart_rx = byte[3:0] when pointer is LO, byte[7:4] when HI.
  - Transfer with pointer LO -> pointer HI.
  - Transfer with pointer HI -> buffer empty, pointer LO.
  - o_uart_rx and vld hold stable while vld && !acp.
- Buffer write in the STOP cycle:
  - Buffer empty, or the last nibble (HI) transfers in the same cycle -> write succeeds, pointer LO, vld stays or becomes 1 next cycle with no bubble.
  - Otherwise -> new byte dropped, o_uart_rx_ovf pulses that cycle, buffer contents untouched.
- Simultaneous error and full buffer: report err only.
- Pulses o_uart_rx_ovf and o_uart_rx_err are registered, high for exactly one cycle.
- Reset mid-frame: FSM returns to IDLE and buffer empties immediately (asynchronous). Any partial byte is lost, with no err or ovf pulse.
- The assembly register needs no reset.

Decomposition:
- idli_pkg: add uart_rx_state_t (the FSM enum above). Reuse the existing sqi_data_t.
- Sub-module idli_sync_m: parameterised N-flop synchroniser with reset value 1. Generic, so reusable for other async inputs.
- Everything else stays in idli_uart_rx_m.

Test Plan:
- Single byte: idle, then line 0,1,0,1,0,0,1,0,1,1 (0xA5 LSB first, then stop), acp held 1 -> o_uart_rx 0x5 then 0xA on consecutive cycles. vld first high SYNC_STAGES+10 cycles after the start bit on the pin. No ovf/err.
- Back-to-back: 0x3C then 0xF0 with exactly one high cycle between frames, acp=1 -> nibbles C,3,0,F in order, no ovf.
- Backpressure/overflow: send 0x12, hold acp=0, send 0x34 -> ovf pulses once at 0x34's stop cycle. Then acp=1 yields 2,1 only; vld drops.
- Simultaneous drain: 0x12 buffered, accept its low nibble, then time the HI accept to the stop cycle of 0x34 -> no ovf; outputs 2,1,4,3 with no vld bubble.
- Framing error: start plus 8 data bits, line held 0 for 3 more cycles, then high -> err pulses once, no vld, no new frame during the low run. Next valid frame 0x77 is received correctly.
- Reset mid-frame: assert i_uart_rst_n low during DATA_4 -> vld 0 and no pulses. After release, a fresh 0x81 frame yields 1,8.
